// File: rtl/irq_responder.sv
// Memory-mapped IRQ source at BASE_ADDR; irq_out rises 3 cycles after a synchronised edge, bus never stalls.
// Optional IRQ_LATENCY_EN adds a 16-bit service-latency counter shown in STATUS[31:16].
module irq_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_7F20,
   parameter int          MAX_PENDING = 15,
   parameter int          HOLDOFF     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq_in,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  byteen,
   output logic [31:0] rdata,
   output logic        irq_out,
   output logic        ack_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   localparam logic [7:0] MAX_P = 8'(MAX_PENDING);
   // Timer is loaded one short so the holdoff state lasts HOLDOFF cycles (and one cycle when HOLDOFF=0).
   localparam logic [7:0] HOLD_LOAD = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

   state_t      state, state_nx;
   logic [7:0]  timer, timer_nx;
   logic [7:0]  pending;
   logic        enable, overflow;
   logic [31:0] serviced;
   logic        sync1, sync2, dly, rise;

   logic [31:0] word_addr;
   logic        in_win, wr_en, ack, ctrl_wr;
   logic [1:0]  reg_sel;
   logic [31:0] status;
   logic        unused_wdata;

   assign word_addr    = addr & ~32'd3;
   assign in_win       = (word_addr >= BASE_ADDR) && (word_addr <= BASE_ADDR + 32'd12);
   assign reg_sel      = word_addr[3:2] - BASE_ADDR[3:2];
   assign wr_en        = (byteen != 4'd0) && in_win;
   assign ack          = wr_en && (reg_sel == 2'd0);
   assign ctrl_wr      = wr_en && (reg_sel == 2'd2);
   assign unused_wdata = &{1'b0, wdata[31:3], wdata[1]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign rise = sync2 & ~dly;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending   <= 8'd0;
         overflow  <= 1'b0;
         enable    <= 1'b1;
         serviced  <= 32'd0;
         ack_pulse <= 1'b0;
      end else begin
         ack_pulse <= ack;
         if (ack)
            serviced <= serviced + 32'd1;
         if (ctrl_wr) begin
            enable <= wdata[0];
            if (wdata[2])
               overflow <= 1'b0;
         end
         // A rise coinciding with an acknowledge cancels out.
         if (rise && !ack) begin
            if (pending == MAX_P)
               overflow <= 1'b1;
            else
               pending <= pending + 8'd1;
         end else if (ack && !rise && pending != 8'd0) begin
            pending <= pending - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         timer <= 8'd0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
         ST_IDLE: begin
            if (pending != 8'd0 && enable)
               state_nx = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (ack) begin
               state_nx = ST_HOLDOFF;
               timer_nx = HOLD_LOAD;
            end else if (!enable) begin
               state_nx = ST_IDLE;
            end
         end
         ST_HOLDOFF: begin
            if (timer == 8'd0)
               state_nx = (pending != 8'd0 && enable) ? ST_ACTIVE : ST_IDLE;
            else
               timer_nx = timer - 8'd1;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign irq_out = (state == ST_ACTIVE);

`ifdef IRQ_LATENCY_EN
   logic [15:0] lat_cnt;
   logic        lat_run;

   // Counts cycles from IDLE->ACTIVE up to and including the acknowledging edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt <= 16'd0;
         lat_run <= 1'b0;
      end else if (state == ST_IDLE && state_nx == ST_ACTIVE) begin
         lat_cnt <= 16'd0;
         lat_run <= 1'b1;
      end else if (lat_run) begin
         if (lat_cnt != 16'hFFFF)
            lat_cnt <= lat_cnt + 16'd1;
         if (ack)
            lat_run <= 1'b0;
      end
   end

   assign status = {lat_cnt, pending, 5'd0, overflow, enable, irq_out};
`else
   assign status = {14'd0, state, pending, 5'd0, overflow, enable, irq_out};
`endif

   always_comb begin
      rdata = 32'd0;
      if (in_win) begin
         case (reg_sel)
            2'd1:    rdata = status;
            2'd2:    rdata = {31'd0, enable};
            2'd3:    rdata = serviced;
            default: rdata = 32'd0;
         endcase
      end
   end

endmodule
